// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
//   Shared definitions for the tick generator: channel-index width helper,
//   the channel-count ceiling and the per-channel state record.
//   Channel state is held at MAX_CNT_W bits; CNT_W must not exceed it.
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_CNT_W = 32;

    typedef logic [MAX_CNT_W-1:0] cnt_t;

    // Per-channel state: running count, active divisor, and a one-deep
    // holding slot for a divisor waiting for the next wrap.
    typedef struct packed {
        cnt_t cnt;
        cnt_t div;
        logic pend;
        cnt_t pend_div;
    } tick_ch_state_t;

    // Channel-select width; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_generator_if.sv
// -----------------------------------------------------------------------------
// tick_generator_if
//   Divisor-programming port plus per-channel enable outputs.
//   master: drives cfg_valid/cfg_ch/cfg_div, observes cfg_ready/tick/sq/active
//   slave : the tick generator side
// -----------------------------------------------------------------------------
interface tick_generator_if
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = ch_width(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] active;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, tick, sq, active
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, tick, sq, active
    );

endinterface

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
//   One clock-enable channel: counts to its divisor, pulses tick for one cycle
//   at each wrap and toggles sq there. A new divisor is parked in a pending
//   slot and swapped in at the next wrap (or next edge when disabled).
//   Optional TICKGEN_SYNC_EN adds a sync input that restarts the phase.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   sync          phase restart (TICKGEN_SYNC_EN only)
//   wr_en, wr_div accepted divisor write for this channel
//   tick, sq      registered enable pulse and 50 % square wave
//   active        registered "divisor nonzero"
//   pend          a divisor is waiting to be applied (gates cfg_ready)
// -----------------------------------------------------------------------------
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef TICKGEN_SYNC_EN
    input  logic             sync,
`endif
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             active,
    output logic             pend
);

    tick_ch_state_t st;
    logic           enabled;
    logic           wrap;

    assign enabled = (st.div != '0);
    assign wrap    = enabled && (st.cnt == st.div - cnt_t'(1));
    assign pend    = st.pend;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st.cnt      <= '0;
            st.div      <= cnt_t'(DEFAULT_DIV);
            st.pend     <= 1'b0;
            st.pend_div <= '0;
            tick        <= 1'b0;
            sq          <= 1'b0;
            active      <= (DEFAULT_DIV != 0);
        end
`ifdef TICKGEN_SYNC_EN
        else if (sync) begin
            st.cnt <= '0;
            tick   <= 1'b0;
            sq     <= 1'b0;
            if (st.pend) begin
                st.div  <= st.pend_div;
                st.pend <= 1'b0;
                active  <= (st.pend_div != '0);
            end
            // A write on the sync edge waits for the next wrap.
            if (wr_en) begin
                st.pend     <= 1'b1;
                st.pend_div <= cnt_t'(wr_div);
            end
        end
`endif
        else begin
            if (!enabled) begin
                st.cnt <= '0;
                tick   <= 1'b0;
            end else if (wrap) begin
                st.cnt <= '0;
                tick   <= 1'b1;
                sq     <= ~sq;
            end else begin
                st.cnt <= st.cnt + cnt_t'(1);
                tick   <= 1'b0;
            end

            // Swap only at a period boundary so the output never glitches;
            // a disabled channel has no period, so it swaps at once.
            if (st.pend && (wrap || !enabled)) begin
                st.div  <= st.pend_div;
                st.pend <= 1'b0;
                active  <= (st.pend_div != '0);
            end

            // wr_en implies pend was clear, so this never collides with the
            // apply above; a write on a wrap edge lands for the next wrap.
            if (wr_en) begin
                st.pend     <= 1'b1;
                st.pend_div <= cnt_t'(wr_div);
            end
        end
    end

endmodule

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
//   Multi-channel programmable clock-enable generator. Each channel emits a
//   one-cycle tick every div cycles and a square wave of period 2*div.
//   Divisors are written through a valid/ready port and take effect at the
//   channel's next wrap.
//   Define TICKGEN_SYNC_EN to add the sync input (phase restart of all
//   channels); without it channels only phase-align through reset.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   sync     phase restart, TICKGEN_SYNC_EN only
//   bus      tick_generator_if.slave: cfg_valid/cfg_ready/cfg_ch/cfg_div,
//            tick/sq/active per channel
// -----------------------------------------------------------------------------
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef TICKGEN_SYNC_EN
    input  logic                sync,
`endif
    tick_generator_if.slave     bus
);

    localparam int CH_W   = ch_width(NUM_CH);
    localparam int PEND_W = 2 ** CH_W;

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr_en;
    logic [PEND_W-1:0] pend_ext;
    logic              in_range;
    logic              ready;

    // Zero-padded so any cfg_ch value indexes a defined bit.
    assign pend_ext = PEND_W'(pend);
    assign in_range = (int'(bus.cfg_ch) < NUM_CH);

    // Out-of-range channels always accept; their writes simply go nowhere.
    assign ready         = in_range ? ~pend_ext[bus.cfg_ch] : 1'b1;
    assign bus.cfg_ready = ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = bus.cfg_valid && ready && (bus.cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
`ifdef TICKGEN_SYNC_EN
            .sync    (sync),
`endif
            .wr_en   (wr_en[i]),
            .wr_div  (bus.cfg_div),
            .tick    (bus.tick[i]),
            .sq      (bus.sq[i]),
            .active  (bus.active[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// -----------------------------------------------------------------------------
// tb_tick_generator
//   NUM_CH=3 so channel index 3 is out of range, CNT_W=8, DEFAULT_DIV=4.
//   The reference model tracks, per channel, the absolute cycle of the next
//   tick; outputs are derived from that schedule, not from a counter.
// -----------------------------------------------------------------------------
module tb_tick_generator;

    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;
    localparam int CH_W        = tick_gen_pkg::ch_width(NUM_CH);

    logic clk = 1'b0;
    logic reset_n;
    logic sync = 1'b0;

    always #5 clk = ~clk;

    tick_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    tick_generator #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef TICKGEN_SYNC_EN
        .sync    (sync),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned cyc = 0;
    bit          model_ok = 1'b0;
    int unsigned m_div  [NUM_CH];
    int unsigned m_pdiv [NUM_CH];
    int unsigned m_next [NUM_CH];
    bit          m_pend [NUM_CH];
    bit          m_tick [NUM_CH];
    bit          m_sq   [NUM_CH];

    function automatic bit exp_ready();
        if (int'(bus.cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[bus.cfg_ch];
    endfunction

    always @(posedge clk) begin
        int acc;
        bit do_apply;
        cyc++;
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c]  = DEFAULT_DIV;
                m_pend[c] = 1'b0;
                m_tick[c] = 1'b0;
                m_sq[c]   = 1'b0;
                m_next[c] = cyc + DEFAULT_DIV;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc = -1;
            if (bus.cfg_valid && exp_ready() && int'(bus.cfg_ch) < NUM_CH)
                acc = int'(bus.cfg_ch);
            for (int c = 0; c < NUM_CH; c++) begin
                do_apply = 1'b0;
`ifdef TICKGEN_SYNC_EN
                if (sync) begin
                    m_tick[c] = 1'b0;
                    m_sq[c]   = 1'b0;
                    do_apply  = m_pend[c];
                    if (do_apply) begin m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0; end
                    m_next[c] = cyc + m_div[c];
                end else
`endif
                if (m_div[c] == 0) begin
                    m_tick[c] = 1'b0;
                    if (m_pend[c]) begin
                        m_div[c]  = m_pdiv[c];
                        m_pend[c] = 1'b0;
                        m_next[c] = cyc + m_div[c];
                    end
                end else if (cyc == m_next[c]) begin
                    m_tick[c] = 1'b1;
                    m_sq[c]   = !m_sq[c];
                    if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0; end
                    m_next[c] = cyc + m_div[c];
                end else begin
                    m_tick[c] = 1'b0;
                end
                if (c == acc) begin
                    m_pend[c] = 1'b1;
                    m_pdiv[c] = int'(bus.cfg_div);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                check($sformatf("tick[%0d]@%0d", c, cyc), 32'(bus.tick[c]), 32'(m_tick[c]));
                check($sformatf("sq[%0d]@%0d", c, cyc), 32'(bus.sq[c]), 32'(m_sq[c]));
                check($sformatf("active[%0d]@%0d", c, cyc), 32'(bus.active[c]), 32'(m_div[c] != 0));
            end
            check($sformatf("cfg_ready@%0d", cyc), 32'(bus.cfg_ready), 32'(exp_ready()));
        end
    end

    // ---------------- stimulus ----------------
    logic t0 [1:26];
    logic s0 [1:26];
    logic t1 [1:26];
    logic r1 [1:26];

    initial begin
        reset_n       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = CH_W'(1);
        bus.cfg_div   = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed: k counts edges after the last reset edge.
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk);
            @(negedge clk);
            t0[k] = bus.tick[0];
            s0[k] = bus.sq[0];
            t1[k] = bus.tick[1];
            r1[k] = bus.cfg_ready;
            if (k == 1) check("active after reset", 32'(bus.active), 32'h7);
            if (k == 4) check("model tick0@4", 32'(m_tick[0]), 32'h1);
            if (k == 8) check("model sq0@8", 32'(m_sq[0]), 32'h0);
            #1;
            bus.cfg_valid = (k == 1) || (k == 15);
            bus.cfg_ch    = (k >= 15) ? CH_W'(0) : CH_W'(1);
            bus.cfg_div   = (k >= 15) ? CNT_W'(5) : CNT_W'(3);
        end
        bus.cfg_valid = 1'b0;

        check("t0@3", 32'(t0[3]), 0);
        check("t0@4", 32'(t0[4]), 1);
        check("t0@5", 32'(t0[5]), 0);
        check("t0@8", 32'(t0[8]), 1);
        check("t0@12", 32'(t0[12]), 1);
        check("s0@4", 32'(s0[4]), 1);
        check("s0@7", 32'(s0[7]), 1);
        check("s0@8", 32'(s0[8]), 0);
        check("r1@1", 32'(r1[1]), 1);
        check("r1@2", 32'(r1[2]), 0);
        check("r1@3", 32'(r1[3]), 0);
        check("r1@4", 32'(r1[4]), 1);
        check("t1@4", 32'(t1[4]), 1);
        check("t1@6", 32'(t1[6]), 0);
        check("t1@7", 32'(t1[7]), 1);
        check("t1@10", 32'(t1[10]), 1);
        check("t1@13", 32'(t1[13]), 1);
        check("t0@16 wrap-edge write", 32'(t0[16]), 1);
        check("t0@20 old period", 32'(t0[20]), 1);
        check("t0@24", 32'(t0[24]), 0);
        check("t0@25 new period", 32'(t0[25]), 1);

        // Out-of-range channel: always ready, write dropped.
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = CH_W'(3);
        bus.cfg_div   = CNT_W'(1);
        @(negedge clk);
        check("oor ready", 32'(bus.cfg_ready), 1);
        #1;
        // div=1 on channel 2.
        bus.cfg_ch = CH_W'(2);
        @(negedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("div1 tick a", 32'(bus.tick[2]), 1);
        @(negedge clk);
        check("div1 tick b", 32'(bus.tick[2]), 1);
        check("active unchanged", 32'(bus.active), 32'h7);

        // Randomized phase with occasional reset (and sync if built in).
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            reset_n       = ($urandom_range(0, 599) != 0);
            sync          = ($urandom_range(0, 149) == 0);
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_ch    = CH_W'($urandom_range(0, 3));
            bus.cfg_div   = ($urandom_range(0, 9) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 7));
        end
        @(negedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        sync          = 1'b0;
        reset_n       = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
